// File: rtl/mod_up_down_counter.sv
// Programmable-modulus up/down counter: variable step, synchronous load, wrap/saturate, registered tc.
// Define MUD_CNT_STICKY_FLAGS_EN to build the sticky ovf/unf flags; otherwise they are tied low.
module mod_up_down_counter #(
  parameter int             N       = 8,
  parameter int             STEP_W  = 4,
  parameter logic [N-1:0]   RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  input  logic [N-1:0]      max_val,
  input  logic              sat,
  input  logic              load,
  input  logic [N-1:0]      load_val,
  input  logic              clr_flags,
  output logic [N-1:0]      q,
  output logic              tc,
  output logic              ovf,
  output logic              unf
);

  // All arithmetic is carried at N+1 bits so q+s and q+modulus never lose their carry before compare.
  logic [N:0]   max_ext;
  logic [N:0]   mod_ext;
  logic [N:0]   step_ext;
  logic [N:0]   s;
  logic [N:0]   q_ext;
  logic [N:0]   sum_up;
  logic [N:0]   wrap_up;
  logic [N:0]   diff_dn;
  logic [N:0]   wrap_dn;

  logic [N-1:0] q_next;
  logic         tc_next;
  logic         hit_ovf;
  logic         hit_unf;

  assign max_ext  = {1'b0, max_val};
  assign mod_ext  = max_ext + (N+1)'(1);
  assign step_ext = (N+1)'(step);
  assign s        = (step_ext < mod_ext) ? step_ext : mod_ext;
  assign q_ext    = {1'b0, q};
  assign sum_up   = q_ext + s;
  assign wrap_up  = sum_up - mod_ext;
  assign diff_dn  = q_ext - s;
  assign wrap_dn  = q_ext + mod_ext - s;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    q_next  = q;
    tc_next = 1'b0;
    hit_ovf = 1'b0;
    hit_unf = 1'b0;
    if (load) begin
      q_next = (load_val > max_val) ? max_val : load_val;
    end else if (en && (step != '0)) begin
      if (q > max_val) begin
        // Range shrank underneath q: treat as an overflow crossing whatever the direction.
        q_next  = sat ? max_val : '0;
        tc_next = 1'b1;
        hit_ovf = 1'b1;
      end else if (up) begin
        if (sum_up <= max_ext) begin
          q_next = sum_up[N-1:0];
        end else begin
          q_next  = sat ? max_val : wrap_up[N-1:0];
          tc_next = 1'b1;
          hit_ovf = 1'b1;
        end
      end else begin
        if (q_ext >= s) begin
          q_next = diff_dn[N-1:0];
        end else begin
          q_next  = sat ? '0 : wrap_dn[N-1:0];
          tc_next = 1'b1;
          hit_unf = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q  <= RST_VAL;
      tc <= 1'b0;
    end else begin
      q  <= q_next;
      tc <= tc_next;
    end
  end

`ifdef MUD_CNT_STICKY_FLAGS_EN
  // A crossing in the same cycle as clr_flags wins, so the flag ends set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= hit_ovf | (ovf & ~clr_flags);
      unf <= hit_unf | (unf & ~clr_flags);
    end
  end
`else
  logic unused_flags;
  assign unused_flags = ^{clr_flags, hit_ovf, hit_unf};
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_mod_up_down_counter.sv
// Self-checking bench for mod_up_down_counter: directed scenarios plus randomized run against an
// arithmetic reference model (modulo arithmetic on plain integers).
module tb_mod_up_down_counter;

  localparam int N = 8;
  localparam int STEP_W = 4;
`ifdef MUD_CNT_STICKY_FLAGS_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic              up;
  logic [STEP_W-1:0] step;
  logic [N-1:0]      max_val;
  logic              sat;
  logic              load;
  logic [N-1:0]      load_val;
  logic              clr_flags;
  logic [N-1:0]      q;
  logic              tc;
  logic              ovf;
  logic              unf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_q   = 0;
  bit m_tc  = 1'b0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  mod_up_down_counter #(.N(N), .STEP_W(STEP_W), .RST_VAL('0)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .step(step), .max_val(max_val),
    .sat(sat), .load(load), .load_val(load_val), .clr_flags(clr_flags),
    .q(q), .tc(tc), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  // Advance one clock: update the model from the inputs in force at the edge, then settle.
  task automatic tick();
    int  mx, md, s, st;
    bit  cu, cd;
    @(posedge clk);
    mx = int'(max_val);
    st = int'(step);
    md = mx + 1;
    s  = (st < md) ? st : md;
    cu = 1'b0;
    cd = 1'b0;
    if (!reset_n) begin
      m_q = 0; m_tc = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_tc = 1'b0;
      if (load) begin
        m_q = (int'(load_val) < mx) ? int'(load_val) : mx;
      end else if (en && st != 0) begin
        m_tc = 1'b1;
        if (m_q > mx) begin
          m_q = sat ? mx : 0; cu = 1'b1;
        end else if (up) begin
          if (m_q + s <= mx) begin m_q = m_q + s; m_tc = 1'b0; end
          else begin m_q = sat ? mx : (m_q + s) % md; cu = 1'b1; end
        end else begin
          if (m_q >= s) begin m_q = m_q - s; m_tc = 1'b0; end
          else begin m_q = sat ? 0 : ((m_q - s) % md + md) % md; cd = 1'b1; end
        end
      end
      if (STICKY) begin
        if (clr_flags) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (cu) m_ovf = 1'b1;
        if (cd) m_unf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    reset_n = 1'b1; en = 1'b0; up = 1'b1; step = '0; sat = 1'b0;
    load = 1'b0; load_val = '0; clr_flags = 1'b0;
  endtask

  task automatic do_load(input int v, input int mx);
    max_val = N'(mx); load_val = N'(v); load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    max_val = 8'd255;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    n_tests++;
    if ({q, tc, ovf, unf} !== {8'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset: got q=%0d tc=%b ovf=%b unf=%b, want q=0 tc=0 ovf=0 unf=0", q, tc, ovf, unf);
    end
  endtask

  task automatic test_wrap_up();
    int eq;
    bit et;
    max_val = 8'd9; sat = 1'b0; up = 1'b1; step = 4'd1; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      eq = (i + 1) % 10;
      et = (i == 9);
      n_tests++;
      if (q !== N'(eq) || tc !== et) begin
        n_fail++;
        $display("FAIL wrap_up[%0d]: got q=%0d tc=%b, want q=%0d tc=%b", i, q, tc, eq, et);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap_down();
    int eq[4] = '{8, 5, 2, 9};
    bit et[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_load(1, 9);
    sat = 1'b0; up = 1'b0; step = 4'd3; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (q !== N'(eq[i]) || tc !== et[i]) begin
        n_fail++;
        $display("FAIL wrap_down[%0d]: got q=%0d tc=%b, want q=%0d tc=%b", i, q, tc, eq[i], et[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    int eq[4] = '{200, 200, 200, 185};
    bit et[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    en = 1'b0;
    do_load(190, 200);
    sat = 1'b1; up = 1'b1; step = 4'd15; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) up = 1'b0;
      tick();
      n_tests++;
      if (q !== N'(eq[i]) || tc !== et[i]) begin
        n_fail++;
        $display("FAIL saturate[%0d]: got q=%0d tc=%b, want q=%0d tc=%b", i, q, tc, eq[i], et[i]);
      end
    end
    en = 1'b0; sat = 1'b0;
  endtask

  task automatic test_load_reset();
    en = 1'b1; up = 1'b1; step = 4'd2; sat = 1'b0;
    do_load(250, 100);
    n_tests++;
    if (q !== 8'd100 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL load_clamp: got q=%0d tc=%b, want q=100 tc=0", q, tc);
    end
    tick();
    n_tests++;
    if (q !== 8'd1 || tc !== 1'b1) begin
      n_fail++;
      $display("FAIL load_count: got q=%0d tc=%b, want q=1 tc=1", q, tc);
    end
    reset_n = 1'b0; load = 1'b1; load_val = 8'd50;
    tick();
    reset_n = 1'b1; load = 1'b0; en = 1'b0;
    n_tests++;
    if (q !== 8'd0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_over_load: got q=%0d tc=%b, want q=0 tc=0", q, tc);
    end
  endtask

  task automatic test_boundary();
    en = 1'b0;
    do_load(5, 20);
    max_val = 8'd3; up = 1'b0; step = 4'd1; sat = 1'b1; en = 1'b1;
    tick();
    n_tests++;
    if (q !== 8'd3 || tc !== 1'b1 || ovf !== STICKY || unf !== 1'b0) begin
      n_fail++;
      $display("FAIL out_of_range_sat: got q=%0d tc=%b ovf=%b unf=%b, want q=3 tc=1 ovf=%b unf=0",
               q, tc, ovf, unf, STICKY);
    end
    max_val = 8'd0; sat = 1'b0; up = 1'b1; step = 4'd5;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (q !== 8'd0 || tc !== 1'b1) begin
        n_fail++;
        $display("FAIL max_zero[%0d]: got q=%0d tc=%b, want q=0 tc=1", i, q, tc);
      end
    end
    step = 4'd0;
    tick();
    n_tests++;
    if (q !== 8'd0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL step_zero_hold: got q=%0d tc=%b, want q=0 tc=0", q, tc);
    end
    en = 1'b0;
    do_load(2, 4);
    step = 4'd15; up = 1'b1; en = 1'b1;
    tick();
    n_tests++;
    if (q !== 8'd2 || tc !== 1'b1) begin
      n_fail++;
      $display("FAIL step_clamp: got q=%0d tc=%b, want q=2 tc=1", q, tc);
    end
    en = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_flags();
    bit eo[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit eu[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    en = 1'b0; sat = 1'b0;
    do_load(8, 9);
    step = 4'd3;
    for (int i = 0; i < 5; i++) begin
      en = (i != 2 && i != 4); up = (i != 1); clr_flags = (i >= 3);
      tick();
      n_tests++;
      if (ovf !== (eo[i] & STICKY) || unf !== (eu[i] & STICKY)) begin
        n_fail++;
        $display("FAIL flags[%0d]: got ovf=%b unf=%b, want ovf=%b unf=%b",
                 i, ovf, unf, eo[i] & STICKY, eu[i] & STICKY);
      end
    end
    clr_flags = 1'b0; en = 1'b0;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 800; i++) begin
      reset_n   = ($urandom_range(0, 49) != 0);
      load      = ($urandom_range(0, 9) == 0);
      load_val  = N'($urandom);
      en        = ($urandom_range(0, 3) != 0);
      up        = $urandom_range(0, 1);
      step      = STEP_W'($urandom);
      sat       = $urandom_range(0, 1);
      clr_flags = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0)
        max_val = ($urandom_range(0, 1) != 0) ? N'($urandom_range(0, 15)) : N'($urandom);
      tick();
      n_tests++;
      if (q !== N'(m_q) || tc !== m_tc || ovf !== m_ovf || unf !== m_unf) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: got q=%0d tc=%b ovf=%b unf=%b, want q=%0d tc=%b ovf=%b unf=%b",
                   i, q, tc, ovf, unf, m_q, m_tc, m_ovf, m_unf);
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    max_val = 8'd255;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_reset();
    test_boundary();
    test_flags();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
